// File: rtl/elastic_buffer.sv
// rtl/elastic_buffer.sv - DEPTH-entry valid/ready elastic buffer with flush and occupancy
module elastic_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter bit READY_PASS = 1'b0,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  not_full;
    logic                  push;
    logic                  pop;

    // Explicit compare-and-wrap so non-power-of-two depths cycle correctly
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign not_full  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0) && !flush;
    assign out_data  = mem[rd_ptr];
    assign count     = count_q;

    generate
        if (READY_PASS) begin : g_ready_pass
            assign in_ready = (not_full || out_ready) && !flush;
        end else begin : g_ready_reg
            assign in_ready = not_full && !flush;
        end
    endgenerate

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_elastic_buffer.sv
// tb/tb_elastic_buffer.sv - scoreboard bench for elastic_buffer across depth/ready-pass variants
module tb_elastic_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        $display("FAIL %s: unexpected beat 0x%0h expected none", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // a: DEPTH=4 RP0, b: DEPTH=3 RP0, c: DEPTH=3 RP1, d: DEPTH=1 RP0, e: DEPTH=1 RP1
    logic       a_fl = 0, a_iv = 0, a_ir, a_ov, a_or = 1;
    logic [7:0] a_id = 0, a_od;
    logic [2:0] a_cnt;
    logic       b_fl = 0, b_iv = 0, b_ir, b_ov, b_or = 0;
    logic [7:0] b_id = 0, b_od;
    logic [1:0] b_cnt;
    logic       c_fl = 0, c_iv = 0, c_ir, c_ov, c_or = 0;
    logic [7:0] c_id = 0, c_od;
    logic [1:0] c_cnt;
    logic       d_fl = 0, d_iv = 0, d_ir, d_ov, d_or = 0;
    logic [7:0] d_id = 0, d_od;
    logic [0:0] d_cnt;
    logic       e_fl = 0, e_iv = 0, e_ir, e_ov, e_or = 0;
    logic [7:0] e_id = 0, e_od;
    logic [0:0] e_cnt;

    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(4), .READY_PASS(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .count(a_cnt));
    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(3), .READY_PASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .count(b_cnt));
    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(3), .READY_PASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .count(c_cnt));
    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(1), .READY_PASS(0)) u_d (
        .clk(clk), .rst_n(rst_n), .flush(d_fl), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .count(d_cnt));
    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(1), .READY_PASS(1)) u_e (
        .clk(clk), .rst_n(rst_n), .flush(e_fl), .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id),
        .out_valid(e_ov), .out_ready(e_or), .out_data(e_od), .count(e_cnt));

    logic [7:0] qb[$];
    logic [7:0] qc[$];
    logic [7:0] qd[$];
    logic [7:0] qe[$];
    int d_in = 0, e_in = 0, d_out = 0, e_out = 0;

    // Monitors: pop expected beats whenever a DUT completes an output handshake
    always @(negedge clk) begin
        if (a_ov && a_or) unexpected("a_out", a_od);
        if (b_ov && b_or) begin
            if (qb.size() == 0) unexpected("b_out", b_od);
            else chk("b_out", b_od, qb.pop_front());
        end
        if (c_ov && c_or) begin
            if (qc.size() == 0) unexpected("c_out", c_od);
            else chk("c_out", c_od, qc.pop_front());
        end
        if (d_ov && d_or) begin
            d_out++;
            if (qd.size() == 0) unexpected("d_out", d_od);
            else chk("d_out", d_od, qd.pop_front());
        end
        if (e_ov && e_or) begin
            e_out++;
            if (qe.size() == 0) unexpected("e_out", e_od);
            else chk("e_out", e_od, qe.pop_front());
        end
        if (d_iv && d_ir) d_in++;
        if (e_iv && e_ir) e_in++;
    end

    initial begin
        // Reset state, during and after reset
        #12;
        chk("rst_ov", a_ov, 0);
        chk("rst_ir", a_ir, 1);
        chk("rst_od", a_od, 0);
        #10 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("idle_ov", a_ov, 0);
            chk("idle_od", a_od, 0);
            chk("idle_ir", a_ir, 1);
            chk("idle_cnt", a_cnt, 0);
            tick();
        end

        // Fill/drain DEPTH=3 READY_PASS=0
        for (int i = 0; i < 3; i++) begin
            b_iv = 1; b_id = 8'hA1 + 8'(i); qb.push_back(b_id);
            chk("fill_ir", b_ir, 1);
            tick();
            chk("fill_cnt", b_cnt, i + 1);
        end
        b_id = 8'hEE; b_or = 1; #1;
        chk("full_ir", b_ir, 0);
        chk("full_head", b_od, 8'hA1);
        tick();
        b_iv = 0; #1;
        chk("ir_after_pop", b_ir, 1);
        chk("drain_cnt2", b_cnt, 2);
        tick();
        chk("drain_cnt1", b_cnt, 1);
        tick();
        chk("drain_cnt0", b_cnt, 0);
        chk("drain_ov", b_ov, 0);
        b_or = 0;

        // Wrap and full-rate DEPTH=3 READY_PASS=1
        for (int i = 0; i < 3; i++) begin
            c_iv = 1; c_id = 8'hC0 + 8'(i); qc.push_back(c_id);
            tick();
        end
        c_or = 1;
        for (int i = 0; i < 10; i++) begin
            c_id = 8'(i); qc.push_back(c_id); #1;
            chk("stream_ir", c_ir, 1);
            chk("stream_cnt", c_cnt, 3);
            tick();
        end
        c_iv = 0;
        tick(); tick(); tick();
        chk("stream_end_cnt", c_cnt, 0);
        c_or = 0;

        // DEPTH=1: continuous flow, RP0 accepts every other cycle, RP1 every cycle
        qd = '{8'd0, 8'd2, 8'd4, 8'd6};
        qe = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        d_iv = 1; e_iv = 1; d_or = 1; e_or = 1;
        for (int k = 0; k < 8; k++) begin
            d_id = 8'(k); e_id = 8'(k);
            tick();
        end
        d_iv = 0; e_iv = 0;
        tick(); tick();
        chk("d1_rp0_in", d_in, 4);
        chk("d1_rp1_in", e_in, 8);
        chk("d1_rp0_out", d_out, 4);
        chk("d1_rp1_out", e_out, 8);
        d_or = 0; e_or = 0;

        // Flush with two entries and in_valid high
        b_iv = 1; b_id = 8'h11; tick();
        b_id = 8'h22; tick();
        chk("pre_flush_cnt", b_cnt, 2);
        b_id = 8'h33; b_fl = 1; #1;
        chk("flush_ir", b_ir, 0);
        chk("flush_ov", b_ov, 0);
        tick();
        b_fl = 0; b_id = 8'h55; qb.push_back(8'h55); #1;
        chk("post_flush_cnt", b_cnt, 0);
        tick();
        b_iv = 0; #1;
        chk("flush_push_cnt", b_cnt, 1);
        chk("flush_push_od", b_od, 8'h55);
        b_or = 1;
        tick();
        chk("flush_drain_cnt", b_cnt, 0);
        b_or = 0;

        // Asynchronous reset mid-operation with two stalled entries
        b_iv = 1; b_id = 8'h66; tick();
        b_id = 8'h67; tick();
        b_iv = 0;
        chk("pre_rst_ov", b_ov, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", b_ov, 0);
        chk("mid_rst_cnt", b_cnt, 0);
        chk("mid_rst_od", b_od, 0);
        #1 rst_n = 1'b1;
        tick();
        b_iv = 1; b_id = 8'h77; qb.push_back(8'h77);
        tick();
        b_iv = 0; #1;
        chk("post_rst_od", b_od, 8'h77);
        chk("post_rst_cnt", b_cnt, 1);
        b_or = 1;
        tick();
        b_or = 0;
        tick();

        chk("qb_empty", qb.size(), 0);
        chk("qc_empty", qc.size(), 0);
        chk("qd_empty", qd.size(), 0);
        chk("qe_empty", qe.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
